// File: rtl/reg_file_pkg.sv
// Shared constants for the MIPS register file: special register indices,
// instruction field positions and default widths.
package reg_file_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam int REG_ZERO = 0;
  localparam int REG_RA   = 31;

  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;

  localparam int FIELD_W = RS_HI - RS_LO + 1;

  // Register-index field whose top bit sits at position hi.
  function automatic logic [FIELD_W-1:0] reg_field(input logic [31:0] instr, input int hi);
    return instr[hi -: FIELD_W];
  endfunction

endpackage

// File: rtl/reg_wsel.sv
// Write-back target select: picks the destination index and value for the
// single write port (link overrides both the rd/rt choice and the data).
module reg_wsel
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int LINK_REG = REG_RA
) (
  input  logic              link,
  input  logic              reg_dst,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [31:0]       link_pc,
  input  logic [DATA_W-1:0] write_data,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata
);

  always_comb begin
    waddr = reg_dst ? rd : rt;
    wdata = write_data;
    if (link) begin
      waddr = ADDR_W'(LINK_REG);
      wdata = DATA_W'(link_pc);
    end
  end

endmodule

// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports, one clocked
// write-back port. Define REG_FILE_BYPASS_EN for same-cycle write-through reads.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int LINK_REG = REG_RA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instruction,
  input  logic [31:0]       link_pc,
  input  logic              RegWrite,
  input  logic              RegDst,
  input  logic              Link,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [ADDR_W-1:0] waddr_dbg,
  output logic [31:0]       wcount
);

  localparam int NREG = 1 << ADDR_W;

  logic [ADDR_W-1:0] rs, rt, rd;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              commit;
  logic [DATA_W-1:0] regs [NREG];

  // Opcode, shamt and funct belong to the decoder, not to this block.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instruction[31:RS_HI+1], instruction[RD_LO-1:0]};

  assign rs = ADDR_W'(reg_field(instruction, RS_HI));
  assign rt = ADDR_W'(reg_field(instruction, RT_HI));
  assign rd = ADDR_W'(reg_field(instruction, RD_HI));

  reg_wsel #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .LINK_REG (LINK_REG)
  ) u_wsel (
    .link       (Link),
    .reg_dst    (RegDst),
    .rt         (rt),
    .rd         (rd),
    .link_pc    (link_pc),
    .write_data (WriteData),
    .waddr      (waddr),
    .wdata      (wdata)
  );

  // $0 is hard-wired: a write aimed at it never commits, so regs[0] stays 0.
  assign commit = RegWrite && (waddr != ADDR_W'(REG_ZERO));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      waddr_dbg <= '0;
      wcount    <= '0;
    end else if (commit) begin
      regs[waddr] <= wdata;
      waddr_dbg   <= waddr;
      wcount      <= wcount + 32'd1;
    end
  end

  always_comb begin
    rdata1 = (rs == ADDR_W'(REG_ZERO)) ? '0 : regs[rs];
    rdata2 = (rt == ADDR_W'(REG_ZERO)) ? '0 : regs[rt];
`ifdef REG_FILE_BYPASS_EN
    // Forward the pending write; suppressed in reset since it will not land.
    if (commit && !rst && (rs == waddr)) rdata1 = wdata;
    if (commit && !rst && (rt == waddr)) rdata2 = wdata;
`endif
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: a behavioural register-array model checked on
// every falling edge, plus literal expectations at key points.
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic [31:0] link_pc;
  logic        reg_write;
  logic        reg_dst;
  logic        link;
  logic [31:0] write_data;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [4:0]  waddr_dbg;
  logic [31:0] wcount;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: what the architecture says the registers hold.
  logic [31:0] m_regs [32];
  logic [31:0] m_wcount;
  logic [4:0]  m_waddr;

  reg_file dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .link_pc     (link_pc),
    .RegWrite    (reg_write),
    .RegDst      (reg_dst),
    .Link        (link),
    .WriteData   (write_data),
    .rdata1      (rdata1),
    .rdata2      (rdata2),
    .waddr_dbg   (waddr_dbg),
    .wcount      (wcount)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [31:0] mk_instr(input int rs_i, input int rt_i, input int rd_i);
    logic [31:0] w;
    w = 32'h0;
    w[25:21] = rs_i[4:0];
    w[20:16] = rt_i[4:0];
    w[15:11] = rd_i[4:0];
    return w;
  endfunction

  function automatic int tgt_index();
    if (link) return 31;
    return reg_dst ? int'(instruction[15:11]) : int'(instruction[20:16]);
  endfunction

  function automatic logic [31:0] tgt_value();
    return link ? link_pc : write_data;
  endfunction

  function automatic logic [31:0] model_read(input int idx);
    if (idx == 0) return 32'h0;
`ifdef REG_FILE_BYPASS_EN
    if (!rst && reg_write && tgt_index() != 0 && tgt_index() == idx) return tgt_value();
`endif
    return rst ? 32'h0 : m_regs[idx];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- model ----------------
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_wcount = 32'h0;
      m_waddr  = 5'd0;
    end else if (reg_write && tgt_index() != 0) begin
      m_regs[tgt_index()] = tgt_value();
      m_waddr  = 5'(tgt_index());
      m_wcount = m_wcount + 32'd1;
    end
  end

  // ---------------- compare ----------------
  always @(negedge clk) begin
    check("cyc_rdata1", rdata1, model_read(int'(instruction[25:21])));
    check("cyc_rdata2", rdata2, model_read(int'(instruction[20:16])));
    check("cyc_wcount", wcount, m_wcount);
    check("cyc_waddr_dbg", {27'h0, waddr_dbg}, {27'h0, m_waddr});
  end

  // ---------------- driver ----------------
  task automatic drive(input logic [31:0] instr, input logic we, input logic dst,
                       input logic lnk, input logic [31:0] wd, input logic [31:0] lpc);
    instruction = instr;
    reg_write   = we;
    reg_dst     = dst;
    link        = lnk;
    write_data  = wd;
    link_pc     = lpc;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_read(input int rs_i, input int rt_i);
    drive(mk_instr(rs_i, rt_i, 0), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    idle_read(1, 31);
    check("reset_rdata1", rdata1, 32'h0);
    check("reset_rdata2", rdata2, 32'h0);
    check("reset_wcount", wcount, 32'h0);
    check("reset_waddr", {27'h0, waddr_dbg}, 32'h0);

    // rd write via R-type encoding
    drive(32'h01095020, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0);
    tick();
    check("rd_waddr", {27'h0, waddr_dbg}, 32'd10);
    check("rd_wcount", wcount, 32'd1);
    idle_read(10, 9);
    check("rd_readback", rdata1, 32'hDEADBEEF);
    check("rd_rt_untouched", rdata2, 32'h0);

    // rt=0 write is discarded
    drive(mk_instr(0, 0, 4), 1'b1, 1'b0, 1'b0, 32'h1234, 32'h0);
    tick();
    check("zero_rdata2", rdata2, 32'h0);
    check("zero_wcount", wcount, 32'd1);
    check("zero_waddr", {27'h0, waddr_dbg}, 32'd10);

    // rt=5 write (rd=4 must be ignored with RegDst=0)
    drive(mk_instr(5, 5, 4), 1'b1, 1'b0, 1'b0, 32'h1234, 32'h0);
    tick();
    idle_read(5, 4);
    check("rt_readback", rdata1, 32'h1234);
    check("rt_rd_untouched", rdata2, 32'h0);
    check("rt_wcount", wcount, 32'd2);

    // link write overrides rd and WriteData
    drive(mk_instr(3, 31, 3), 1'b1, 1'b1, 1'b1, 32'hFFFF, 32'h00003008);
    tick();
    idle_read(3, 31);
    check("link_r3", rdata1, 32'h0);
    check("link_r31", rdata2, 32'h00003008);
    check("link_waddr", {27'h0, waddr_dbg}, 32'd31);
    check("link_wcount", wcount, 32'd3);

    // link without RegWrite does nothing
    drive(mk_instr(31, 3, 3), 1'b0, 1'b1, 1'b1, 32'h5555, 32'h0000AAAA);
    tick();
    check("link_nowe_r31", rdata1, 32'h00003008);
    check("link_nowe_wcount", wcount, 32'd3);

    // same-cycle read/write of R7
    drive(mk_instr(7, 7, 7), 1'b1, 1'b1, 1'b0, 32'h11, 32'h0);
    tick();
    drive(mk_instr(7, 7, 7), 1'b1, 1'b1, 1'b0, 32'h22, 32'h0);
    #1;
`ifdef REG_FILE_BYPASS_EN
    check("same_cyc_rdata1", rdata1, 32'h22);
    check("same_cyc_rdata2", rdata2, 32'h22);
`else
    check("same_cyc_rdata1", rdata1, 32'h11);
    check("same_cyc_rdata2", rdata2, 32'h11);
`endif
    tick();
    idle_read(7, 7);
    check("after_edge_rdata1", rdata1, 32'h22);
    check("after_edge_rdata2", rdata2, 32'h22);
    check("after_edge_wcount", wcount, 32'd5);

    // a spread of rd/rt writes, checked by the per-cycle compare
    for (int i = 1; i < 8; i++) begin
      drive(mk_instr(i * 4, i * 3, i * 4), 1'b1, i[0], 1'b0, 32'hA000_0000 + 32'(i * 16'h0101), 32'h0);
      tick();
    end
    for (int i = 0; i < 32; i += 2) begin
      idle_read(i, i + 1);
      tick();
    end

    // asynchronous reset mid-cycle with a pending write
    drive(mk_instr(10, 31, 12), 1'b1, 1'b1, 1'b0, 32'h55, 32'h0);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_r10", rdata1, 32'h0);
    check("async_rst_r31", rdata2, 32'h0);
    check("async_rst_wcount", wcount, 32'h0);
    check("async_rst_waddr", {27'h0, waddr_dbg}, 32'h0);
    drive(mk_instr(12, 31, 12), 1'b1, 1'b1, 1'b0, 32'h55, 32'h0);
    tick();
    check("rst_hold_r12", rdata1, 32'h0);
    check("rst_hold_wcount", wcount, 32'h0);
    drive(mk_instr(12, 10, 12), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    tick();
    check("post_rst_r12", rdata1, 32'h0);
    check("post_rst_r10", rdata2, 32'h0);
    drive(mk_instr(12, 12, 12), 1'b1, 1'b1, 1'b0, 32'h77, 32'h0);
    tick();
    idle_read(12, 31);
    check("restart_r12", rdata1, 32'h77);
    check("restart_wcount", wcount, 32'd1);
    check("restart_waddr", {27'h0, waddr_dbg}, 32'd12);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file of the single-cycle MIPS datapath, directly downstream of the instruction fetcher.
- Consumes the fetched 32-bit instruction word and the fetcher's return-address output (link PC). It extracts the rs, rt and rd fields itself.
- Provides two combinational read ports to the ALU stage.
- Performs the single clocked write-back per cycle, including the jal link write to $31.

Parameters:
- DATA_W, 32, register width.
- ADDR_W, 5, register index width (2**ADDR_W registers).
- LINK_REG, 31, index written by link (jal) instructions.

Ports:
- clk  in  1  system clock; all writes on rising edge.
- rst  in  1  asynchronous, active-high reset; clears every register.
- instruction  in  32  current instruction; rs=[25:21], rt=[20:16], rd=[15:11].
- link_pc  in  32  return address from fetcher (B_PC).
- RegWrite  in  1  write enable for this cycle.
- RegDst  in  1  1: write to rd; 0: write to rt.
- Link  in  1  1: write link_pc to LINK_REG, overriding RegDst and WriteData.
- WriteData  in  DATA_W  write-back value from ALU/memory mux.
- rdata1  out  DATA_W  value of register rs.
- rdata2  out  DATA_W  value of register rt.
- waddr_dbg  out  ADDR_W  registered index of the last committed write (0 if none since reset).
- wcount  out  32  number of committed, non-$0 writes since reset.

Behaviour:
- Reset (asynchronous, rst high): all 32 registers = 0, waddr_dbg = 0, wcount = 0, independent of clk. While rst is high, writes are ignored. Reset may assert mid-cycle and overrides any pending write.
- Reads are combinational, zero latency: rdata1 = R[rs], rdata2 = R[rt]. Reading index 0 always returns 0.
- Write-address select: waddr = Link ? LINK_REG : (RegDst ? rd : rt).
- Write-data select: wdata = Link ? link_pc : WriteData.
- Commit: on posedge clk with rst low, RegWrite=1 and waddr≠0, set R[waddr] ← wdata, waddr_dbg ← waddr, wcount ← wcount+1.
- wcount wraps from 0xFFFFFFFF to 0 silently.
- $0 write (waddr=0, RegWrite=1): discarded. R[0], waddr_dbg and wcount are unchanged.
- Link=1 with RegWrite=0: no write. Link alone does not imply a write.
- RegWrite=0: no state change.
- Read/write same index in the same cycle (see Optional Feature): the default without the macro returns the old value; the new value is visible after the edge.
- Exactly one write port. Simultaneous writes are impossible by construction.
- No X propagation: all outputs are defined from reset onward.

Optional Feature:
- Macro REG_FILE_BYPASS_EN.
- Defined: write-through bypass. If RegWrite=1, waddr≠0 and rs (or rt) == waddr, then rdata1 (or rdata2) = wdata combinationally in the same cycle.
- Undefined: no bypass. Reads always return stored contents; the write is visible from the cycle after the edge.

Decomposition:
- Shared package/header holds:
  - REG_ZERO=0 and REG_RA=31.
  - Instruction field bit positions (RS_HI/LO, RT_HI/LO, RD_HI/LO).
  - DATA_W/ADDR_W defaults.
  - The decoder uses the same field constants.
- One natural sub-module, reg_wsel: combinational waddr/wdata select from Link/RegDst/instruction/link_pc/WriteData. This is reused by the write-back trace logic.

Test Plan:
- Reset: assert rst between clock edges → all reads 0, wcount=0, waddr_dbg=0 immediately without a clock edge.
- rd write: instruction=0x01095020 (rs=8, rt=9, rd=10), RegDst=1, RegWrite=1, WriteData=0xDEADBEEF, one edge → R10=0xDEADBEEF, waddr_dbg=10, wcount=1. Then instruction with rs=10 → rdata1=0xDEADBEEF.
- rt write and $0 discard:
  - RegDst=0, rt=0, RegWrite=1, WriteData=0x1234 → rdata for rt=0 stays 0, wcount unchanged.
  - rt=5 → R5=0x1234.
- Link: Link=1, RegWrite=1, RegDst=1, rd=3, link_pc=0x00003008, WriteData=0xFFFF → R31=0x00003008, R3 unchanged, waddr_dbg=31.
- Same-cycle read/write: rs=rt=7, R7=0x11, write 0x22 to 7.
  - Macro undefined: rdata1=rdata2=0x11 before the edge, 0x22 after.
  - Macro defined: 0x22 before the edge.
- Reset mid-operation: R31 and R10 populated, rst pulse asynchronously between edges while RegWrite=1 → all registers 0, no write occurs at the next edge while rst is high, and wcount restarts at 0.
